bus_grant_encoder: RTL and testbench
====================================

BUS_GRANT_ENCODER -- requirements
Module: bus_grant_encoder

Interface
REQ-001 Parameter HOLD_MAX, default 15: maximum cycles a grant waits for ack before timeout; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 clr  input  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
REQ-004 req  input  32  drive requests; bit i set = source i wants the 32:1 bus mux.
REQ-005 ack  input  1  consumer has captured the bus value this cycle.
REQ-006 sel  output  5  registered mux select, index of the granted source.
REQ-007 grant  output  32  registered one-hot grant, bit sel set while valid, else all zero.
REQ-008 valid  output  1  bus holds a granted source's data.
REQ-009 multi_req  output  1  one-cycle pulse: more than one req bit was set at grant time.
REQ-010 timeout  output  1  one-cycle pulse: grant abandoned after HOLD_MAX cycles without ack.
REQ-011 conflict_cnt  output  8  saturating count of multi-request grants.

Function
REQ-012 The block SHALL implement two states, IDLE and GRANT, plus a 5-bit round-robin pointer ptr and a 4-bit hold counter.
REQ-013 In IDLE: valid=0, grant=0, sel retains last value; if req!=0 at a rising edge, the block SHALL select the first set req bit at index >= ptr, wrapping 31->0, and enter GRANT.
REQ-014 Latency: req sampled at edge N -> sel, grant, valid=1 visible after edge N, i.e. valid high in cycle N+1.
REQ-015 In GRANT with ack=1 at an edge: valid=0, grant=0, ptr=(sel+1) mod 32, next state IDLE; minimum one IDLE cycle between grants.
REQ-016 In GRANT without ack: hold counter increments each edge; counter counts cycles since valid rose, starting at 0.
REQ-017 When the hold counter reaches HOLD_MAX without ack: timeout=1 for one cycle, valid=0, grant=0, ptr=(sel+1) mod 32, next state IDLE.
REQ-018 Simultaneous ack and timeout condition: ack wins, timeout stays 0.
REQ-019 If req[sel] drops while in GRANT and ack=0: grant aborted at that edge, valid=0, ptr=(sel+1) mod 32, no timeout pulse.
REQ-020 ack in IDLE SHALL be ignored.
REQ-021 Requests changing in GRANT other than req[sel] SHALL not affect sel, grant, or the hold counter.
REQ-022 At IDLE->GRANT with popcount(req)>=2: multi_req=1 concurrent with valid's first cycle; conflict_cnt increments, saturating at 255.
REQ-023 multi_req and timeout SHALL be 0 in every cycle other than those specified.
REQ-024 ptr wraps: sel=31 released -> ptr=0.

Reset
REQ-025 clr low SHALL immediately force: state IDLE, ptr=0, hold counter=0, sel=0, grant=0, valid=0, multi_req=0, timeout=0, conflict_cnt=0.
REQ-026 Reset asserted mid-GRANT SHALL drop valid asynchronously; after release, the first grant SHALL follow REQ-013 with ptr=0.

Verification
REQ-027 After reset, req=0x0000_0010 held, ack high in second valid cycle -> sel=4, grant=0x10, valid high 2 cycles, multi_req=0, then ptr=5.
REQ-028 req=0x8000_0001 held, ack each grant's first valid cycle -> grants alternate sel=0, 31, 0, ..., one idle cycle between; conflict_cnt increments each grant.
REQ-029 req=0x0000_0100, ack never -> valid high HOLD_MAX+1 cycles (16 at default), timeout pulse 1 cycle, state IDLE, regrant after one idle cycle.
REQ-030 ack asserted on exactly the timeout cycle -> no timeout pulse, normal release.
REQ-031 Granted req bit cleared mid-GRANT -> valid falls next edge, no timeout, next grant starts at sel+1.
REQ-032 300 multi-request grants -> conflict_cnt saturates at 255; clr pulse mid-GRANT -> all outputs 0 immediately.

Source files
------------

// File: rtl/bus_grant_encoder.sv
// Round-robin 32:1 bus grant encoder: picks one requester, holds the grant until
// ack, request withdrawal or hold timeout, and counts contended grants.
module bus_grant_encoder #(
   parameter int HOLD_MAX = 15
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] req,
   input  logic        ack,
   output logic [4:0]  sel,
   output logic [31:0] grant,
   output logic        valid,
   output logic        multi_req,
   output logic        timeout,
   output logic [7:0]  conflict_cnt
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

   state_t      state_r, state_nxt_s;
   logic [4:0]  ptr_r, ptr_nxt_s;
   logic [4:0]  sel_r, sel_nxt_s;
   logic [3:0]  hold_r, hold_nxt_s;
   logic [31:0] grant_r, grant_nxt_s;
   logic        valid_r, valid_nxt_s;
   logic        multi_r, multi_nxt_s;
   logic        timeout_r, timeout_nxt_s;
   logic [7:0]  cnt_r, cnt_nxt_s;
   logic [4:0]  pick_s;
   logic        multi_s;

   // Rotate so index p sits at bit 0, take the lowest set bit, rotate back.
   function automatic logic [4:0] rr_pick(input logic [31:0] r, input logic [4:0] p);
      logic [63:0] dbl;
      logic [31:0] rot;
      logic [4:0]  off;
      dbl = {r, r} >> p;
      rot = dbl[31:0];
      off = 5'd0;
      for (int i = 31; i >= 0; i--) begin
         if (rot[i]) begin
            off = 5'(i);
         end else begin
            off = off;
         end
      end
      return p + off;
   endfunction

   assign pick_s  = rr_pick(req, ptr_r);
   assign multi_s = ((req & (req - 32'd1)) != 32'd0);

   // Next-state and next-output decode for the grant FSM.
   always_comb begin
      state_nxt_s   = state_r;
      ptr_nxt_s     = ptr_r;
      sel_nxt_s     = sel_r;
      hold_nxt_s    = hold_r;
      grant_nxt_s   = grant_r;
      valid_nxt_s   = valid_r;
      multi_nxt_s   = 1'b0;
      timeout_nxt_s = 1'b0;
      cnt_nxt_s     = cnt_r;
      case (state_r)
         IDLE: begin
            if (req != 32'd0) begin
               state_nxt_s = GRANT;
               sel_nxt_s   = pick_s;
               grant_nxt_s = 32'd1 << pick_s;
               valid_nxt_s = 1'b1;
               hold_nxt_s  = 4'd0;
               if (multi_s) begin
                  multi_nxt_s = 1'b1;
                  if (cnt_r != 8'hFF) begin
                     cnt_nxt_s = cnt_r + 8'd1;
                  end else begin
                     cnt_nxt_s = cnt_r;
                  end
               end else begin
                  multi_nxt_s = 1'b0;
               end
            end else begin
               grant_nxt_s = 32'd0;
               valid_nxt_s = 1'b0;
            end
         end
         GRANT: begin
            // ack beats both withdrawal and timeout; withdrawal never pulses timeout
            if (ack || !req[sel_r]) begin
               state_nxt_s = IDLE;
               grant_nxt_s = 32'd0;
               valid_nxt_s = 1'b0;
               hold_nxt_s  = 4'd0;
               ptr_nxt_s   = sel_r + 5'd1;
            end else if (hold_r == HOLD_LIM) begin
               state_nxt_s   = IDLE;
               grant_nxt_s   = 32'd0;
               valid_nxt_s   = 1'b0;
               hold_nxt_s    = 4'd0;
               ptr_nxt_s     = sel_r + 5'd1;
               timeout_nxt_s = 1'b1;
            end else begin
               hold_nxt_s = hold_r + 4'd1;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            grant_nxt_s = 32'd0;
            valid_nxt_s = 1'b0;
            hold_nxt_s  = 4'd0;
         end
      endcase
   end

   // State and registered-output storage with asynchronous clear.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_r   <= IDLE;
         ptr_r     <= 5'd0;
         sel_r     <= 5'd0;
         hold_r    <= 4'd0;
         grant_r   <= 32'd0;
         valid_r   <= 1'b0;
         multi_r   <= 1'b0;
         timeout_r <= 1'b0;
         cnt_r     <= 8'd0;
      end else begin
         state_r   <= state_nxt_s;
         ptr_r     <= ptr_nxt_s;
         sel_r     <= sel_nxt_s;
         hold_r    <= hold_nxt_s;
         grant_r   <= grant_nxt_s;
         valid_r   <= valid_nxt_s;
         multi_r   <= multi_nxt_s;
         timeout_r <= timeout_nxt_s;
         cnt_r     <= cnt_nxt_s;
      end
   end

   assign sel          = sel_r;
   assign grant        = grant_r;
   assign valid        = valid_r;
   assign multi_req    = multi_r;
   assign timeout      = timeout_r;
   assign conflict_cnt = cnt_r;

endmodule

// File: tb/tb_bus_grant_encoder.sv
// Scoreboard bench for bus_grant_encoder: a behavioural model pushes the expected
// outputs at each edge, and they are popped and compared just after the edge.
module tb_bus_grant_encoder;
   localparam int HOLD_MAX = 15;

   logic        clk = 1'b0;
   logic        clr;
   logic [31:0] req;
   logic        ack;
   logic [4:0]  sel;
   logic [31:0] grant;
   logic        valid;
   logic        multi_req;
   logic        timeout;
   logic [7:0]  conflict_cnt;

   always #5 clk = ~clk;

   bus_grant_encoder #(.HOLD_MAX(HOLD_MAX)) dut (
      .clk(clk), .clr(clr), .req(req), .ack(ack), .sel(sel), .grant(grant),
      .valid(valid), .multi_req(multi_req), .timeout(timeout), .conflict_cnt(conflict_cnt)
   );

   typedef struct packed {
      logic [4:0]  sel;
      logic [31:0] grant;
      logic        valid;
      logic        multi;
      logic        to;
      logic [7:0]  cnt;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   bit m_valid, m_multi, m_to;
   int m_ptr, m_sel, m_hold, m_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_multi = 0; m_to = 0;
      m_ptr = 0; m_sel = 0; m_hold = 0; m_cnt = 0;
      sb.delete();
   endtask

   task automatic model_step();
      exp_t e;
      bit   found;
      m_multi = 0;
      m_to    = 0;
      if (!m_valid) begin
         if (req != 32'd0) begin
            found = 0;
            for (int i = 0; i < 32; i++) begin
               if (!found && req[(m_ptr + i) % 32]) begin
                  m_sel = (m_ptr + i) % 32;
                  found = 1;
               end
            end
            m_valid = 1;
            m_hold  = 0;
            if ($countones(req) >= 2) begin
               m_multi = 1;
               if (m_cnt < 255) m_cnt++;
            end
         end
      end else if (ack || !req[m_sel]) begin
         m_valid = 0;
         m_ptr   = (m_sel + 1) % 32;
      end else if (m_hold == HOLD_MAX) begin
         m_valid = 0;
         m_to    = 1;
         m_ptr   = (m_sel + 1) % 32;
      end else begin
         m_hold++;
      end
      e.sel   = 5'(m_sel);
      e.grant = m_valid ? (32'd1 << m_sel) : 32'd0;
      e.valid = m_valid;
      e.multi = m_multi;
      e.to    = m_to;
      e.cnt   = 8'(m_cnt);
      sb.push_back(e);
   endtask

   task automatic cycle();
      exp_t e;
      @(posedge clk);
      model_step();
      #1;
      if (sb.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL sb_empty: got no entry, expected one");
      end else begin
         e = sb.pop_front();
         chk("sel", 32'(sel), 32'(e.sel));
         chk("grant", grant, e.grant);
         chk("valid", 32'(valid), 32'(e.valid));
         chk("multi_req", 32'(multi_req), 32'(e.multi));
         chk("timeout", 32'(timeout), 32'(e.to));
         chk("conflict_cnt", 32'(conflict_cnt), 32'(e.cnt));
      end
   endtask

   task automatic zero_chk();
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_grant", grant, 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_multi", 32'(multi_req), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      chk("rst_cnt", 32'(conflict_cnt), 32'd0);
   endtask

   task automatic drain();
      req = 32'd0;
      ack = 1'b0;
      repeat (2) cycle();
   endtask

   initial begin
      int  vcnt, run, tos, ng, grants;
      bit  seen, prev_v;
      clr = 1'b0;
      req = 32'd0;
      ack = 1'b0;
      #1;
      zero_chk();
      model_reset();
      @(negedge clk);
      clr = 1'b1;

      // single requester, ack in second valid cycle
      req = 32'h0000_0010;
      vcnt = 0;
      for (int k = 0; k < 10; k++) begin
         ack = m_valid && (m_hold == 1);
         cycle();
         if (valid) vcnt++;
         if (vcnt > 0 && !valid) break;
      end
      chk("ack2_vlen", 32'(vcnt), 32'd2);
      ack = 1'b0;
      req = 32'h0000_0030;
      cycle();
      chk("ptr5_sel", 32'(sel), 32'd5);
      drain();

      // two-way alternation with immediate ack
      req = 32'h8000_0001;
      for (int k = 0; k < 12; k++) begin
         ack = m_valid;
         cycle();
      end
      drain();

      // no ack: timeout after HOLD_MAX+1 valid cycles, then regrant
      req = 32'h0000_0100;
      ack = 1'b0;
      run = 0;
      seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
         cycle();
         if (valid) run++;
         else if (run > 0) begin
            seen = 1;
            chk("to_pulse", 32'(timeout), 32'd1);
         end
      end
      chk("to_vlen", 32'(run), 32'(HOLD_MAX + 1));
      cycle();
      chk("regrant", 32'(valid), 32'd1);
      drain();

      // ack exactly on the timeout cycle
      req = 32'h0000_0100;
      tos = 0;
      for (int k = 0; k < 25; k++) begin
         ack = m_valid && (m_hold == HOLD_MAX);
         cycle();
         if (timeout) tos++;
      end
      chk("ack_wins", 32'(tos), 32'd0);
      drain();

      // granted bit withdrawn mid-grant; ptr is 9 here so first pick wraps to 4
      req = 32'h0000_00F0;
      ack = 1'b0;
      ng = 0;
      prev_v = 0;
      for (int k = 0; k < 8; k++) begin
         if (m_valid && m_hold == 2) req = req & ~(32'd1 << m_sel);
         cycle();
         if (valid && !prev_v) begin
            ng++;
            if (ng == 1) chk("drop_first", 32'(sel), 32'd4);
            if (ng == 2) chk("drop_next", 32'(sel), 32'd5);
         end
         prev_v = valid;
      end
      drain();

      // random traffic
      for (int k = 0; k < 200; k++) begin
         req = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom & $urandom & $urandom);
         ack = ($urandom_range(0, 3) == 0);
         cycle();
      end
      drain();

      // saturate the conflict counter
      req = 32'hFFFF_FFFF;
      grants = 0;
      for (int k = 0; k < 700 && grants < 300; k++) begin
         ack = m_valid;
         cycle();
         if (multi_req) grants++;
      end
      chk("cnt_sat", 32'(conflict_cnt), 32'd255);
      ack = 1'b0;
      for (int k = 0; k < 3 && !valid; k++) cycle();
      chk("pre_rst_valid", 32'(valid), 32'd1);

      // asynchronous clear in the middle of a grant
      #2;
      clr = 1'b0;
      #1;
      zero_chk();
      model_reset();
      req = 32'h8000_0002;
      @(negedge clk);
      clr = 1'b1;
      cycle();
      chk("post_rst_sel", 32'(sel), 32'd1);
      for (int k = 0; k < 6; k++) begin
         ack = m_valid;
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
